if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch front end of the five-stage MIPS pipeline. Holds the program counter, drives the instruction-memory address, and predicts the next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Its outputs feed the IF/ID pipeline register directly. It accepts stall and redirect from the hazard/branch-resolution logic, and BTB training updates from the stage that resolves branches.

## Interface
- BTB_ENTRIES, 16: BTB depth; power of two, 4..256.
- RESET_PC, 32'h0000_0000: PC loaded on reset; word-aligned.
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold PC; same Stall that freezes IF/ID
- redirect_valid  in  1  mispredict or exception redirect; overrides prediction and stall
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- upd_valid  in  1  BTB training strobe for one resolved branch
- upd_pc  in  32  PC of the resolved branch
- upd_target  in  32  resolved taken target
- upd_taken  in  1  resolved direction
- imem_addr  out  32  instruction-memory address; equals if_pc
- if_pc  out  32  current fetch PC
- if_pc_plus_4  out  32  if_pc + 4
- if_btb_hit  out  1  BTB valid tag match on if_pc
- if_branch_likely  out  1  hit and counter predicts taken

## Operation
- BTB index = PC[IDX+1:2], where IDX = log2(BTB_ENTRIES). Tag = PC[31:IDX+2]. Each entry holds valid, tag, target[31:2], ctr[1:0].
- Lookup is combinational on the PC register. if_btb_hit = valid && tag match. if_branch_likely = if_btb_hit && ctr[1].
- Next-PC priority, highest first:
  - reset: RESET_PC
  - redirect_valid: {redirect_pc[31:2], 2'b00}
  - stall: PC unchanged
  - if_branch_likely: BTB target
  - otherwise: PC + 4
- PC + 4 wraps modulo 2^32: 32'hFFFF_FFFC is followed by 32'h0000_0000. PC[1:0] is always 0.
- Training, when upd_valid is high; it is independent of stall and redirect:
  - Tag hit at upd_pc's index: ctr saturates up on taken and down on not-taken, clamped to 00..11. Target is written only when taken.
  - Miss and taken: allocate or replace the entry with valid=1, tag, target, ctr=2'b10.
  - Miss and not taken: no change.
- A training write and a lookup to the same index in the same cycle: the lookup sees the pre-write contents. The write lands at the clock edge.
- This block inserts no bubbles. Flushing IF/ID on redirect is the hazard unit's job.

## Timing
- Reset values:
  - if_pc = imem_addr = RESET_PC
  - if_pc_plus_4 = RESET_PC + 4
  - if_btb_hit = 0, if_branch_likely = 0
  - all BTB valid bits = 0, all counters = 2'b01
- Reset is asynchronous. Asserting it mid-fetch or mid-update discards the in-flight update.
- Next-PC latency is one cycle: a decision made in cycle n appears on if_pc in cycle n+1. This covers redirect, prediction and sequential fetch alike.
- Training latency is one cycle: an update in cycle n is visible to lookups from cycle n+1.
- redirect_valid and stall in the same cycle: redirect wins and the PC loads redirect_pc.
- The stall hold repeats the same imem_addr and the same BTB outputs every cycle until stall drops. Training still updates during a stall, so the hold output can change if the held PC's entry is trained.

## Configuration
- BTB_PREDICT_EN, when defined: BTB storage, lookup, and training are built as described above.
- When undefined: no BTB storage; if_btb_hit = if_branch_likely = 0; next PC is RESET_PC / redirect / hold / PC + 4 only; upd_* inputs are ignored. Port list is unchanged.

## Structure
- Shared package `mips_pkg`:
  - RESET_PC default
  - counter encodings: STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11
  - BTB entry struct typedef
  - saturating-counter update function
- One sub-module, `btb_table`: storage, combinational lookup port, synchronous training port, async clear.
- `if_fetch_stage` itself keeps only the PC register and next-PC mux.

## Test plan
- Reset: hold reset with RESET_PC=0 → if_pc=0, if_pc_plus_4=4, hit=0, likely=0. After release, sequential PCs are 0, 4, 8.
- Train and predict: upd_valid with upd_pc=0x40, upd_target=0x100, taken. Next fetch of 0x40 gives hit=1, likely=1, and the following if_pc is 0x100.
- Counter decay: from WEAK_T, apply two not-taken updates for 0x40 → hit=1, likely=0, next PC 0x44. One more taken update → still likely=0 (WEAK_NT).
- Redirect over stall: stall=1 and redirect_valid=1 with redirect_pc=0x203 in the same cycle → next if_pc=0x200. With stall alone, PC holds for 3 cycles.
- Wrap: redirect to 0xFFFF_FFFC with no BTB hit → next if_pc=0x0, if_pc_plus_4 at 0xFFFF_FFFC reads 0x0.
- Same-cycle collision: update allocates index k while fetching a PC that maps to k → hit=0 that cycle, hit=1 on the next fetch of the trained PC. Without BTB_PREDICT_EN, the same stimulus never yields hit.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types, reset PC default, and the BTB saturating-counter helper.
package mips_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [29:0] target;
    ctr_t        ctr;
  } btb_entry_t;
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    return taken ? ((c == STRONG_T) ? c : ctr_t'(c + 2'd1))
                 : ((c == STRONG_NT) ? c : ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: control, training and IF/ID-facing signals of the fetch stage.
interface if_fetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] imem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic        if_btb_hit;
  logic        if_branch_likely;
  modport master (
    output stall, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
    input  imem_addr, if_pc, if_pc_plus_4, if_btb_hit, if_branch_likely
  );
  modport slave (
    input  stall, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
    output imem_addr, if_pc, if_pc_plus_4, if_btb_hit, if_branch_likely
  );
endinterface

// File: rtl/btb_table.sv
// btb_table: direct-mapped BTB, combinational lookup, synchronous training, async clear.
module btb_table
  import mips_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] lookup_word,
  output logic        hit,
  output logic        likely,
  output logic [29:0] target,
  input  logic        upd_valid,
  input  logic [29:0] upd_word,
  input  logic [29:0] upd_target,
  input  logic        upd_taken
);
  localparam int IDX = $clog2(ENTRIES);
  btb_entry_t mem [ENTRIES];
  logic [IDX-1:0] l_idx, u_idx;
  logic [29:0] l_tag, u_tag;
  btb_entry_t l_e, u_e;
  logic u_hit;
  always_comb begin
    l_idx  = lookup_word[IDX-1:0];
    l_tag  = lookup_word >> IDX;
    u_idx  = upd_word[IDX-1:0];
    u_tag  = upd_word >> IDX;
    l_e    = mem[l_idx];
    u_e    = mem[u_idx];
    hit    = l_e.valid && (l_e.tag == l_tag);
    likely = hit && l_e.ctr[1];
    target = l_e.target;
    u_hit  = u_e.valid && (u_e.tag == u_tag);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
    end else if (upd_valid) begin
      if (u_hit) begin
        mem[u_idx].ctr <= ctr_next(u_e.ctr, upd_taken);
        if (upd_taken) mem[u_idx].target <= upd_target;
      end else if (upd_taken) begin
        mem[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: WEAK_T};
      end
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register and next-PC mux; BTB prediction built only with BTB_PREDICT_EN.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF
) (
  input logic clk,
  input logic reset,
  if_fetch_stage_if.slave bus
);
  logic [31:0] pc, pc_next, pc4;
  logic [29:0] tgt;
  logic hit, likely;
`ifdef BTB_PREDICT_EN
  btb_table #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (clk),
    .reset      (reset),
    .lookup_word(pc[31:2]),
    .hit        (hit),
    .likely     (likely),
    .target     (tgt),
    .upd_valid  (bus.upd_valid),
    .upd_word   (bus.upd_pc[31:2]),
    .upd_target (bus.upd_target[31:2]),
    .upd_taken  (bus.upd_taken)
  );
`else
  assign hit    = 1'b0;
  assign likely = 1'b0;
  assign tgt    = '0;
`endif
  always_comb begin
    pc4     = pc + 32'd4;
    pc_next = bus.redirect_valid ? {bus.redirect_pc[31:2], 2'b00}
            : bus.stall          ? pc
            : likely             ? {tgt, 2'b00}
            :                      pc4;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= {RESET_PC[31:2], 2'b00};
    else pc <= pc_next;
  end
  assign bus.imem_addr        = pc;
  assign bus.if_pc            = pc;
  assign bus.if_pc_plus_4     = pc4;
  assign bus.if_btb_hit       = hit;
  assign bus.if_branch_likely = likely;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of reset, sequencing, stall/redirect, wrap and BTB training.
module tb_if_fetch_stage;
`ifdef BTB_PREDICT_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  if_fetch_stage_if bus();
  if_fetch_stage #(.BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic redirect(input logic [31:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = a;
    step();
    bus.redirect_valid = 1'b0;
  endtask
  task automatic train(input logic [31:0] a, input logic [31:0] t, input logic tk);
    bus.upd_valid = 1'b1;
    bus.upd_pc = a;
    bus.upd_target = t;
    bus.upd_taken = tk;
    step();
    bus.upd_valid = 1'b0;
  endtask
  initial begin
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.upd_valid = 1'b0;
    bus.upd_pc = '0;
    bus.upd_target = '0;
    bus.upd_taken = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", bus.if_pc, 32'h0);
    chk("rst_imem", bus.imem_addr, 32'h0);
    chk("rst_pc4", bus.if_pc_plus_4, 32'h4);
    chk("rst_hit", {31'b0, bus.if_btb_hit}, 32'h0);
    chk("rst_likely", {31'b0, bus.if_branch_likely}, 32'h0);
    reset = 1'b0;
    step();
    chk("seq_4", bus.if_pc, 32'h4);
    step();
    chk("seq_8", bus.if_pc, 32'h8);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", bus.imem_addr, 32'h8);
    end
    redirect(32'h203);
    bus.stall = 1'b0;
    chk("redir_over_stall", bus.if_pc, 32'h200);
    chk("redir_pc4", bus.if_pc_plus_4, 32'h204);
    redirect(32'hFFFF_FFFC);
    chk("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.if_pc_plus_4, 32'h0);
    step();
    chk("wrap_next", bus.if_pc, 32'h0);
    redirect(32'h40);
    bus.upd_valid = 1'b1;
    bus.upd_pc = 32'h40;
    bus.upd_target = 32'h100;
    bus.upd_taken = 1'b1;
    #1;
    chk("collide_hit", {31'b0, bus.if_btb_hit}, 32'h0);
    step();
    bus.upd_valid = 1'b0;
    chk("collide_next", bus.if_pc, 32'h44);
    redirect(32'h40);
    chk("pred_hit", {31'b0, bus.if_btb_hit}, {31'b0, BTB});
    chk("pred_likely", {31'b0, bus.if_branch_likely}, {31'b0, BTB});
    step();
    chk("pred_target", bus.if_pc, BTB ? 32'h100 : 32'h44);
    train(32'h40, 32'h100, 1'b0);
    train(32'h40, 32'h100, 1'b0);
    redirect(32'h40);
    chk("decay_hit", {31'b0, bus.if_btb_hit}, {31'b0, BTB});
    chk("decay_likely", {31'b0, bus.if_branch_likely}, 32'h0);
    step();
    chk("decay_next", bus.if_pc, 32'h44);
    train(32'h40, 32'h100, 1'b1);
    redirect(32'h40);
    chk("weaknt_likely", {31'b0, bus.if_branch_likely}, 32'h0);
    step();
    chk("weaknt_next", bus.if_pc, 32'h44);
    train(32'h40, 32'h300, 1'b1);
    redirect(32'h40);
    chk("weakt_likely", {31'b0, bus.if_branch_likely}, {31'b0, BTB});
    step();
    chk("retarget", bus.if_pc, BTB ? 32'h300 : 32'h44);
    redirect(32'h80);
    chk("tag_miss", {31'b0, bus.if_btb_hit}, 32'h0);
    bus.stall = 1'b1;
    redirect(32'h40);
    train(32'h40, 32'h300, 1'b0);
    chk("stall_train_hold", bus.if_pc, 32'h40);
    chk("stall_train_likely", {31'b0, bus.if_branch_likely}, 32'h0);
    bus.stall = 1'b0;
    step();
    chk("stall_release", bus.if_pc, 32'h44);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
